alu_addsub_seq: RTL

Parametrised, multi-cycle add/subtract unit for the ALU datapath. It computes A+B+C or A−B−C over WIDTH bits, CHUNK bits per clock, with a proper carry/borrow out and signed-overflow, zero and negative flags. Operands arrive and results leave on valid/ready handshakes, so the ALU controller can issue operations back-to-back and tolerate result backpressure. It replaces fixed-width ripple subtractors wherever a narrower per-cycle adder slice is acceptable.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_addsub_seq_if.sv | 31 +++
 rtl/alu_chunk_addsub.sv | 29 ++
 rtl/alu_addsub_seq.sv | 113 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential add/subtract unit and its
// reusable chunk slice.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/alu_addsub_seq_if.sv
// Operand request and result channels of the sequential add/subtract unit.
interface alu_addsub_seq_if #(
    parameter int WIDTH = 16
) ();
    // Both channels transfer on a rising edge where valid && ready; the
    // producer holds its payload stable until that edge, and a result is
    // held unchanged while it waits for iReady.
    logic             iValid;
    logic             oReady;
    logic             iSub;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iC;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oResult;
    logic             oCarry;
    logic             oOverflow;
    logic             oZero;
    logic             oNegative;

    modport master (
        output iValid, iSub, iA, iB, iC, iReady,
        input  oReady, oValid, oResult, oCarry, oOverflow, oZero, oNegative
    );

    modport slave (
        input  iValid, iSub, iA, iB, iC, iReady,
        output oReady, oValid, oResult, oCarry, oOverflow, oZero, oNegative
    );
endinterface

// File: rtl/alu_chunk_addsub.sv
// Combinational CHUNK-bit add/subtract slice; cout is the carry (add) or
// borrow (sub) out of the slice.
module alu_chunk_addsub
    import alu_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    // One extra bit: for subtraction it goes to 1 exactly when a < b + cin.
    logic [CHUNK:0] ext;

    always_comb begin
        ext = '0;
        case (sub)
            ADD:     ext = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
            SUB:     ext = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, cin};
            default: ext = '0;
        endcase
    end

    assign s    = ext[CHUNK-1:0];
    assign cout = ext[CHUNK];
endmodule

// File: rtl/alu_addsub_seq.sv
// Multi-cycle A+B+C / A-B-C unit: one CHUNK-bit slice per clock, LSB first,
// with carry/borrow, overflow, zero and negative flags on a held result.
module alu_addsub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic   iClk,
    input  logic   iRstN,
    alu_addsub_seq_if.slave bus,
    output state_t dbg_state
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("alu_addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result;
    logic             sub_q;
    logic             carry_q;
    logic [CW-1:0]    k;
    flags_t           flags;

    int               sh;
    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic [CHUNK-1:0] slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] r_next;
    logic             ovf_next;

    assign sh     = int'(k) * CHUNK;
    assign a_k    = CHUNK'(a_q >> sh);
    assign b_k    = CHUNK'(b_q >> sh);
    assign r_next = result | (WIDTH'(slice_s) << sh);

    // Sign rule on the full result; the carry-in only matters through R.
    assign ovf_next = (sub_q ? (a_q[WIDTH-1] != b_q[WIDTH-1])
                             : (a_q[WIDTH-1] == b_q[WIDTH-1]))
                      && (r_next[WIDTH-1] != a_q[WIDTH-1]);

    alu_chunk_addsub #(.CHUNK(CHUNK)) u_slice (
        .a    (a_k),
        .b    (b_k),
        .cin  (carry_q),
        .sub  (sub_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            result  <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            k       <= '0;
            flags   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iValid) begin
                        a_q     <= bus.iA;
                        b_q     <= bus.iB;
                        sub_q   <= bus.iSub;
                        carry_q <= bus.iC;
                        result  <= '0;
                        flags   <= '0;
                        k       <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result  <= r_next;
                    carry_q <= slice_c;
                    k       <= k + 1'b1;
                    if (k == CW'(N - 1)) begin
                        flags.carry    <= slice_c;
                        flags.overflow <= ovf_next;
                        flags.zero     <= (r_next == '0);
                        flags.negative <= r_next[WIDTH-1];
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (bus.iReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oReady    = (state == IDLE);
    assign bus.oValid    = (state == DONE);
    assign bus.oResult   = result;
    assign bus.oCarry    = flags.carry;
    assign bus.oOverflow = flags.overflow;
    assign bus.oZero     = flags.zero;
    assign bus.oNegative = flags.negative;
    assign dbg_state     = state;
endmodule
